// File: rtl/wave_capture_if.sv
// wave_capture_if: sample stream in, waveform RAM write port and buffer select out.
interface wave_capture_if;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;
  modport master (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );
  modport slave (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );
endinterface

// File: rtl/wave_capture.sv
// wave_capture: arms on a rising zero crossing, writes 256 (decimated) samples into the
// hidden RAM half, then flips read_index during the display's idle window.
module wave_capture #(
  parameter int DECIM = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  wave_capture_if.slave bus
);
  typedef enum logic [1:0] {ARMED, ACTIVE, WAIT} state_t;
  localparam logic [3:0] DEC_LAST  = 4'(DECIM - 1);
  localparam logic [3:0] DEC_FIRST = (DECIM == 1) ? 4'd0 : 4'd1;
  state_t      r_state;
  logic [7:0]  r_count;
  logic [3:0]  r_decim;
  logic [15:0] r_prev;
  logic        r_we;
  logic [8:0]  r_addr;
  logic [7:0]  r_sample;
  logic        r_ri;
  logic        w_trig;
  logic [3:0]  w_decim_nxt;
  logic [7:0]  w_data;
  assign w_data      = {~bus.new_sample_in[15], bus.new_sample_in[14:8]};
  assign w_trig      = bus.new_sample_ready && r_prev[15] && !bus.new_sample_in[15];
  assign w_decim_nxt = (r_decim == DEC_LAST) ? 4'd0 : r_decim + 4'd1;
  assign bus.write_enable  = r_we;
  assign bus.write_address = r_addr;
  assign bus.write_sample  = r_sample;
  assign bus.read_index    = r_ri;
  // The write half is always the one the display is not reading.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ARMED;
      r_count  <= 8'd0;
      r_decim  <= 4'd0;
      r_prev   <= 16'd0;
      r_we     <= 1'b0;
      r_addr   <= 9'd0;
      r_sample <= 8'd0;
      r_ri     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (bus.new_sample_ready) r_prev <= bus.new_sample_in;
      case (r_state)
        ARMED: if (w_trig) begin
          r_we     <= 1'b1;
          r_addr   <= {~r_ri, 8'd0};
          r_sample <= w_data;
          r_count  <= 8'd1;
          r_decim  <= DEC_FIRST;
          r_state  <= ACTIVE;
        end
        ACTIVE: if (bus.new_sample_ready) begin
          r_decim <= w_decim_nxt;
          if (r_decim == 4'd0) begin
            r_we     <= 1'b1;
            r_addr   <= {~r_ri, r_count};
            r_sample <= w_data;
            r_count  <= r_count + 8'd1;
            if (r_count == 8'hff) r_state <= WAIT;
          end
        end
        WAIT: if (bus.wave_display_idle) begin
          r_ri    <= ~r_ri;
          r_state <= ARMED;
        end
        default: r_state <= ARMED;
      endcase
    end
  end
endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: directed stimulus with a write scoreboard for DECIM=1 and DECIM=4 instances.
module tb_wave_capture;
  logic clk = 1'b0;
  logic reset_n;
  wave_capture_if w1 ();
  wave_capture_if w4 ();
  wave_capture #(.DECIM(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(w1));
  wave_capture #(.DECIM(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(w4));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int wr1 = 0, wr4 = 0, run1 = 0, max_run1 = 0;
  logic [16:0] q1[$];
  logic [16:0] q4[$];
  logic [16:0] e1, e4;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [16:0] ent(input logic [8:0] a, input logic [15:0] s);
    return {a, ~s[15], s[14:8]};
  endfunction
  task automatic strobe(input logic [15:0] s);
    @(posedge clk); #1;
    w1.new_sample_ready = 1'b1;
    w1.new_sample_in    = s;
  endtask
  task automatic strobe4(input logic [15:0] s);
    @(posedge clk); #1;
    w4.new_sample_ready = 1'b1;
    w4.new_sample_in    = s;
  endtask
  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      w1.new_sample_ready = 1'b0;
      w4.new_sample_ready = 1'b0;
    end
  endtask
  always @(negedge clk) begin
    if (w1.write_enable) begin
      wr1++;
      run1++;
      n_chk++;
      assert (q1.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_write1: observed write addr %0h, expected no write", w1.write_address);
      end
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("wr1_addr", 32'(w1.write_address), 32'(e1[16:8]));
        chk("wr1_data", 32'(w1.write_sample), 32'(e1[7:0]));
      end
    end else begin
      if (run1 > max_run1) max_run1 = run1;
      run1 = 0;
    end
  end
  always @(negedge clk) begin
    if (w4.write_enable) begin
      wr4++;
      n_chk++;
      assert (q4.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_write4: observed write addr %0h, expected no write", w4.write_address);
      end
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        chk("wr4_addr", 32'(w4.write_address), 32'(e4[16:8]));
        chk("wr4_data", 32'(w4.write_sample), 32'(e4[7:0]));
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset_n = 1'b0;
    w1.new_sample_ready = 1'b0; w1.new_sample_in = 16'd0; w1.wave_display_idle = 1'b0;
    w4.new_sample_ready = 1'b0; w4.new_sample_in = 16'd0; w4.wave_display_idle = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(w1.write_enable), 32'd0);
    chk("rst_addr", 32'(w1.write_address), 32'd0);
    chk("rst_data", 32'(w1.write_sample), 32'd0);
    chk("rst_ri", 32'(w1.read_index), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    // no false trigger: +7 first, positives, then -1 -> -2
    strobe(16'd7); gap(1);
    strobe(16'd100); strobe(16'd200); gap(1);
    strobe(16'hffff); gap(1); strobe(16'hfffe); gap(3);
    chk("no_trig_writes", 32'(wr1), 32'd0);
    // capture with gaps between strobes
    strobe(16'hfffb); gap(1);
    q1.push_back(ent(9'd256, 16'd3));
    strobe(16'd3); gap(1);
    for (int i = 0; i < 255; i++) begin
      q1.push_back(ent(9'(257 + i), 16'h1234));
      strobe(16'h1234); gap(1);
    end
    gap(3);
    chk("capA_writes", 32'(wr1), 32'd256);
    chk("capA_q_empty", 32'(q1.size()), 32'd0);
    chk("capA_ri", 32'(w1.read_index), 32'd0);
    strobe(16'hffff); strobe(16'd1); gap(3);
    chk("wait_no_writes", 32'(wr1), 32'd256);
    chk("wait_ri", 32'(w1.read_index), 32'd0);
    @(posedge clk); #1 w1.wave_display_idle = 1'b1;
    @(posedge clk); #1 w1.wave_display_idle = 1'b0;
    chk("flip_ri", 32'(w1.read_index), 32'd1);
    gap(2);
    chk("flip_ri_hold", 32'(w1.read_index), 32'd1);
    // back-to-back ramp crossing zero, into half 0
    wr1 = 0; max_run1 = 0;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] s;
      s = 16'((i - 20) * 256);
      if (i >= 20 && i < 276) q1.push_back(ent({1'b0, 8'(i - 20)}, s));
      strobe(s);
    end
    gap(3);
    chk("ramp_writes", 32'(wr1), 32'd256);
    chk("ramp_run", 32'(max_run1), 32'd256);
    chk("ramp_q_empty", 32'(q1.size()), 32'd0);
    chk("ramp_ri", 32'(w1.read_index), 32'd1);
    // strobe coinciding with idle in WAIT: flip, no trigger evaluation
    strobe(16'hfffd);
    @(posedge clk); #1;
    w1.new_sample_ready = 1'b1; w1.new_sample_in = 16'd5; w1.wave_display_idle = 1'b1;
    @(posedge clk); #1;
    w1.new_sample_ready = 1'b0; w1.wave_display_idle = 1'b0;
    chk("same_cycle_ri", 32'(w1.read_index), 32'd0);
    gap(3);
    chk("same_cycle_no_write", 32'(wr1), 32'd256);
    // idle held high during capture, then async reset after 100 writes
    w1.wave_display_idle = 1'b1;
    strobe(16'hffff);
    q1.push_back(ent(9'd256, 16'd2));
    strobe(16'd2);
    for (int i = 0; i < 99; i++) begin
      q1.push_back(ent(9'(257 + i), 16'h1234));
      strobe(16'h1234);
    end
    @(posedge clk); #1;
    w1.new_sample_ready = 1'b0;
    chk("pre_rst_we", 32'(w1.write_enable), 32'd1);
    chk("pre_rst_addr", 32'(w1.write_address), 32'd355);
    chk("active_ri", 32'(w1.read_index), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(w1.write_enable), 32'd0);
    chk("async_rst_addr", 32'(w1.write_address), 32'd0);
    chk("async_rst_data", 32'(w1.write_sample), 32'd0);
    chk("async_rst_ri", 32'(w1.read_index), 32'd0);
    @(negedge clk);
    q1.delete();
    wr1 = 0;
    reset_n = 1'b1;
    gap(3);
    chk("post_rst_no_write", 32'(wr1), 32'd0);
    strobe(16'hfff9);
    q1.push_back(ent(9'd256, 16'd9));
    strobe(16'd9);
    for (int i = 0; i < 255; i++) begin
      logic [15:0] s;
      s = 16'(i * 16'h0123);
      q1.push_back(ent(9'(257 + i), s));
      strobe(s);
    end
    gap(4);
    chk("cap_idle_writes", 32'(wr1), 32'd256);
    chk("cap_idle_q_empty", 32'(q1.size()), 32'd0);
    chk("idle_high_flip", 32'(w1.read_index), 32'd1);
    gap(6);
    chk("idle_high_one_flip", 32'(w1.read_index), 32'd1);
    w1.wave_display_idle = 1'b0;
    // decimation by 4
    strobe4(16'hffff);
    q4.push_back(ent(9'd256, 16'd0));
    strobe4(16'd0);
    for (int i = 1; i <= 1020; i++) begin
      logic [15:0] s;
      s = 16'(i << 6);
      if (i % 4 == 0) q4.push_back(ent(9'(256 + i / 4), s));
      strobe4(s);
    end
    gap(4);
    chk("decim_writes", 32'(wr4), 32'd256);
    chk("decim_q_empty", 32'(q4.size()), 32'd0);
    chk("decim_ri", 32'(w4.read_index), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wave_capture.md
# wave_capture

Writer side of the double-buffered waveform RAM that the wave display reads. Watches the audio sample stream, arms on a positive-going zero crossing, writes 256 consecutive (optionally decimated) samples into the half of the 512-entry RAM the display is not reading, then waits for the display's idle window before flipping `read_index` so the new capture becomes visible. It sits between the codec sample stream and the RAM write port; the display owns the read port.

## Interface

- `DECIM`, default 1: capture one of every `DECIM` accepted samples while capturing (1..16).

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `new_sample_ready`  in  1  one-cycle strobe; `new_sample_in` is valid this cycle.
- `new_sample_in`  in  16  signed two's-complement audio sample.
- `wave_display_idle`  in  1  high while the display is outside its drawn region; a buffer flip is safe.
- `write_address`  out  9  RAM write address, `{~read_index, count[7:0]}`.
- `write_enable`  out  1  RAM write strobe, one cycle per written sample.
- `write_sample`  out  8  offset-binary sample, `{~s[15], s[14:8]}`.
- `read_index`  out  1  selects the RAM half the display reads.

## Operation

- All outputs are registered. Reset values: `write_enable`=0, `write_address`=0, `write_sample`=0, `read_index`=0. Internal: state=ARMED, `count`=0, `decim_cnt`=0, `prev_sample`=0.
- `prev_sample` loads `new_sample_in` on every `new_sample_ready` in every state.
- State ARMED: on `new_sample_ready`, a trigger occurs when `prev_sample[15]`=1 and `new_sample_in[15]`=0. On trigger: write the triggering sample at `count`=0, set `count`=1, set `decim_cnt`=1 (mod `DECIM`), go to ACTIVE. The first sample after reset cannot trigger because `prev_sample` resets non-negative.
- State ACTIVE: on each `new_sample_ready`, if `decim_cnt`==0, write the sample at `count` and increment `count`. In all cases, `decim_cnt` increments modulo `DECIM`. After the write at `count`=255, `count` wraps to 0 and the state goes to WAIT. Zero crossings are ignored in ACTIVE.
- State WAIT: no writes. Samples still update `prev_sample`. On the first cycle with `wave_display_idle`=1, toggle `read_index` and go to ARMED. That `wave_display_idle` cycle is not otherwise consumed.
- The write half is always `~read_index`. The display never sees a partially written buffer.
- Arithmetic: `count` is 8 bits and wraps. `decim_cnt` is 4 bits and is compared against `DECIM-1`. With `DECIM`=1, every sample is written.

## Timing

- Write latency: `write_enable`, `write_address`, and `write_sample` assert in the cycle after the `new_sample_ready` that produced them. `write_enable` is high for exactly one cycle.
- A full capture spans exactly 256 `write_enable` pulses. Their addresses are `{~read_index, 8'd0}` through `{~read_index, 8'd255}`, in order, with no gaps or repeats.
- The `read_index` toggle is registered. It changes the cycle after the first `wave_display_idle`=1 seen in WAIT, and never changes in ARMED or ACTIVE.
- If `new_sample_ready` and `wave_display_idle` occur in the same WAIT cycle: flip, update `prev_sample`, and do not evaluate the trigger. The trigger is evaluated on the next strobe.
- If `wave_display_idle` is held high continuously, exactly one flip occurs per capture.
- Asserting `reset_n` low mid-capture immediately forces all reset values, including `read_index`=0. The partial buffer is abandoned, with no further writes.
- Back-to-back `new_sample_ready` on consecutive cycles must be handled: one write per qualifying strobe.

## Test plan

- Reset mid-ACTIVE: after 100 writes, pulse `reset_n` low. Required: outputs go to 0 asynchronously. After release, the next capture starts again at address 256 (`read_index`=0 → write half 1).
- Trigger and capture: feed -5, +3, then 255 samples with `new_sample_in`=0x1234, with `wave_display_idle`=0. Required: the first write is address 256 with data 0x80. Next come 255 writes to 257..511 with data 0x92. Then no further writes, and `read_index` stays 0.
- Flip: from WAIT, raise `wave_display_idle` for 1 cycle. Required: `read_index`=1 one cycle later. The next triggered capture writes addresses 0..255.
- No false trigger: feed only positive samples, or a -1→-2 sequence. Required: no `write_enable` ever. The first sample after reset equal to +7 also gives no trigger.
- Decimation: with `DECIM`=4, trigger, then feed 1020 strobes. Required: exactly 256 writes, taken from the trigger sample and every 4th strobe after it.
- Back-to-back strobes: with `new_sample_ready` high for 300 consecutive cycles carrying a ramp that crosses zero, required: 256 consecutive write cycles, each with data equal to the transformed input from one cycle earlier.
